// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler: round-robin frame scheduler for a MAC TX generator.
// Grants one requester at a time, tracks completion/timeout, enforces IPG.
//
// Ports:
//   clk, i_rst_n        clock, async active-low reset
//   i_enable            scheduler enable, sampled in IDLE only
//   i_req               per-requester level request
//   i_eth_type          per-requester EtherType, 16 bits each
//   i_interrupt         per-requester mode byte, 8 bits each
//   i_gen_done          generator frame-complete pulse
//   o_grant             one-hot grant, held through RUN
//   o_gen_start         generator start, held through RUN
//   o_gen_eth_type      latched EtherType of the winner
//   o_gen_interrupt     latched mode byte of the winner
//   o_ack               completion pulse to the winner
//   o_timeout           abandoned-frame pulse
//   o_busy              high in RUN and IPG
//   o_frame_count       saturating completed-frame count
module mac_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IPG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*16-1:0] i_eth_type,
  input  logic [NUM_REQ*8-1:0]  i_interrupt,
  input  logic                  i_gen_done,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_gen_start,
  output logic [15:0]           o_gen_eth_type,
  output logic [7:0]            o_gen_interrupt,
  output logic [NUM_REQ-1:0]    o_ack,
  output logic                  o_timeout,
  output logic                  o_busy,
  output logic [15:0]           o_frame_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] IPG_LAST =
    GW'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_IPG
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [TW-1:0]      run_cnt_q, run_cnt_d;
  logic [GW-1:0]      ipg_cnt_q, ipg_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               start_q, start_d;
  logic [15:0]        eth_q, eth_d;
  logic [7:0]         intr_q, intr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               to_q, to_d;
  logic               busy_q, busy_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic [15:0] eth_a [NUM_REQ];
  logic [7:0]  intr_a [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign eth_a[k]  = i_eth_type[16*k +: 16];
    assign intr_a[k] = i_interrupt[8*k +: 8];
  end

  // Round-robin pick: first set request at or after ptr_q, wrapping.
  logic          found;
  logic [IW-1:0] win;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  logic [IW-1:0] win_nxt;

  assign win_nxt = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  logic run_exit;

  assign run_exit = i_gen_done || (run_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    run_cnt_d   = run_cnt_q;
    ipg_cnt_d   = ipg_cnt_q;
    grant_d     = grant_q;
    start_d     = start_q;
    eth_d       = eth_q;
    intr_d      = intr_q;
    ack_d       = '0;
    to_d        = 1'b0;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_enable && found) begin
          state_d   = S_RUN;
          ptr_d     = win_nxt;
          win_d     = win;
          run_cnt_d = '0;
          grant_d   = ONE << win;
          start_d   = 1'b1;
          eth_d     = eth_a[win];
          intr_d    = intr_a[win];
          busy_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (run_exit) begin
          grant_d = '0;
          start_d = 1'b0;
          // Done has priority over a coincident timeout.
          if (i_gen_done) begin
            ack_d = ONE << win_q;
            if (frame_cnt_q != 16'hFFFF) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end else begin
            to_d = 1'b1;
          end
          if (IPG_CYCLES == 0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_IPG;
            ipg_cnt_d = '0;
          end
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      S_IPG: begin
        if (ipg_cnt_q == IPG_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ipg_cnt_d = ipg_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        start_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      run_cnt_q   <= '0;
      ipg_cnt_q   <= '0;
      grant_q     <= '0;
      start_q     <= 1'b0;
      eth_q       <= '0;
      intr_q      <= '0;
      ack_q       <= '0;
      to_q        <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      run_cnt_q   <= run_cnt_d;
      ipg_cnt_q   <= ipg_cnt_d;
      grant_q     <= grant_d;
      start_q     <= start_d;
      eth_q       <= eth_d;
      intr_q      <= intr_d;
      ack_q       <= ack_d;
      to_q        <= to_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_grant         = grant_q;
  assign o_gen_start     = start_q;
  assign o_gen_eth_type  = eth_q;
  assign o_gen_interrupt = intr_q;
  assign o_ack           = ack_q;
  assign o_timeout       = to_q;
  assign o_busy          = busy_q;
  assign o_frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb_mac_tx_scheduler: scoreboard bench for mac_tx_scheduler.
// dut_a: default timing; dut_b: 16-cycle timeout, no IPG.
module tb_mac_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, done_a, en_b, done_b;
  logic [3:0]  req_a, req_b;
  logic [63:0] eth_in;
  logic [31:0] intr_in;

  logic [3:0]  a_grant, a_ack, b_grant, b_ack;
  logic        a_start, a_to, a_busy;
  logic        b_start, b_to, b_busy;
  logic [15:0] a_eth, a_cnt, b_eth, b_cnt;
  logic [7:0]  a_intr, b_intr;

  mac_tx_scheduler dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en_a),
    .i_req(req_a), .i_eth_type(eth_in),
    .i_interrupt(intr_in), .i_gen_done(done_a),
    .o_grant(a_grant), .o_gen_start(a_start),
    .o_gen_eth_type(a_eth), .o_gen_interrupt(a_intr),
    .o_ack(a_ack), .o_timeout(a_to), .o_busy(a_busy),
    .o_frame_count(a_cnt)
  );

  mac_tx_scheduler #(
    .IPG_CYCLES(0), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en_b),
    .i_req(req_b), .i_eth_type(eth_in),
    .i_interrupt(intr_in), .i_gen_done(done_b),
    .o_grant(b_grant), .o_gen_start(b_start),
    .o_gen_eth_type(b_eth), .o_gen_interrupt(b_intr),
    .o_ack(b_ack), .o_timeout(b_to), .o_busy(b_busy),
    .o_frame_count(b_cnt)
  );

  typedef struct {
    int d; logic [3:0] gr; logic [15:0] eth;
    logic [7:0] intr; int gap;
  } start_t;
  typedef struct {
    int d; logic [3:0] ack; logic [15:0] cnt; int len;
  } ack_t;
  typedef struct {
    int d; logic [15:0] cnt; int len;
  } to_t;

  start_t sq[$];
  ack_t   aq[$];
  to_t    tq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit pst[2], pbz[2];
  int rl[2], ll[2], il[2], lack[2];
  int xipg[2] = '{12, 0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input int d);
    tests++;
    fails++;
    $display("FAIL %s: dut%0d event with nothing expected", nm, d);
  endtask

  task automatic mon(input int d, input logic st,
                     input logic [3:0] gr, input logic [15:0] et,
                     input logic [7:0] it, input logic [3:0] ak,
                     input logic to, input logic [15:0] cnt,
                     input logic bz);
    start_t s;
    ack_t   a;
    to_t    t;
    bit     hit;
    string  p;
    p = $sformatf("d%0d_", d);
    if (st && !pst[d]) begin
      hit = 0;
      for (int i = 0; i < sq.size(); i++)
        if (!hit && sq[i].d == d) begin
          s = sq[i]; sq.delete(i); hit = 1;
        end
      if (!hit) unexp({p, "start"}, d);
      else begin
        chk({p, "grant"}, 32'(gr), 32'(s.gr));
        chk({p, "eth"}, 32'(et), 32'(s.eth));
        chk({p, "intr"}, 32'(it), 32'(s.intr));
        if (s.gap > 0)
          chk({p, "gap"}, 32'(cyc - lack[d]), 32'(s.gap));
      end
    end
    if (st) rl[d]++;
    else if (pst[d]) begin
      ll[d] = rl[d]; rl[d] = 0;
    end
    if (ak != 4'd0) begin
      hit = 0;
      for (int i = 0; i < aq.size(); i++)
        if (!hit && aq[i].d == d) begin
          a = aq[i]; aq.delete(i); hit = 1;
        end
      if (!hit) unexp({p, "ack"}, d);
      else begin
        chk({p, "ack"}, 32'(ak), 32'(a.ack));
        chk({p, "count"}, 32'(cnt), 32'(a.cnt));
        chk({p, "run_len"}, 32'(ll[d]), 32'(a.len));
      end
      lack[d] = cyc;
    end
    if (to) begin
      hit = 0;
      for (int i = 0; i < tq.size(); i++)
        if (!hit && tq[i].d == d) begin
          t = tq[i]; tq.delete(i); hit = 1;
        end
      if (!hit) unexp({p, "timeout"}, d);
      else begin
        chk({p, "to_count"}, 32'(cnt), 32'(t.cnt));
        chk({p, "to_len"}, 32'(ll[d]), 32'(t.len));
      end
    end
    if (bz && !st) il[d]++;
    if (!bz && pbz[d] && il[d] > 0) begin
      chk({p, "ipg_len"}, 32'(il[d]), 32'(xipg[d]));
      il[d] = 0;
    end
    pst[d] = st;
    pbz[d] = bz;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        pst[d] = 0; pbz[d] = 0; rl[d] = 0; il[d] = 0;
      end
    end else begin
      mon(0, a_start, a_grant, a_eth, a_intr,
          a_ack, a_to, a_cnt, a_busy);
      mon(1, b_start, b_grant, b_eth, b_intr,
          b_ack, b_to, b_cnt, b_busy);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int d);
    int k;
    k = 0;
    while (k < 300 && !(d == 0 ? a_start : b_start)) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_start_seen", d), 32'(k < 300), 32'd1);
  endtask

  function automatic logic [15:0] eth_of(input int k);
    return eth_in[16*k +: 16];
  endfunction

  function automatic logic [7:0] intr_of(input int k);
    return intr_in[8*k +: 8];
  endfunction

  task automatic push_s(input int d, input int k, input int gap);
    start_t s;
    s.d = d; s.gr = 4'(1 << k); s.eth = eth_of(k);
    s.intr = intr_of(k); s.gap = gap;
    sq.push_back(s);
  endtask

  task automatic push_a(input int d, input int k,
                        input logic [15:0] c, input int len);
    ack_t a;
    a.d = d; a.ack = 4'(1 << k); a.cnt = c; a.len = len;
    aq.push_back(a);
  endtask

  initial begin
    to_t t;
    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    req_a = '0; req_b = '0;
    done_a = 1'b0; done_b = 1'b0;
    eth_in  = {16'h1003, 16'h0040, 16'h1001, 16'h1000};
    intr_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick(2);
    chk("rst_a_grant", 32'(a_grant), 0);
    chk("rst_a_start", 32'(a_start), 0);
    chk("rst_a_eth", 32'(a_eth), 0);
    chk("rst_a_intr", 32'(a_intr), 0);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_a_to", 32'(a_to), 0);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_cnt", 32'(a_cnt), 0);
    chk("rst_b_start", 32'(b_start), 0);
    chk("rst_b_cnt", 32'(b_cnt), 0);
    rst_n = 1'b1;
    tick(2);

    // Single requester, done 20 cycles after start.
    push_s(0, 2, 0);
    push_a(0, 2, 16'd1, 21);
    req_a = 4'b0100;
    tick(1);
    chk("latency_grant", 32'(a_grant), 32'h4);
    req_a = 4'b0000;
    eth_in[47:32] = 16'hBEEF;
    tick(3);
    chk("eth_hold", 32'(a_eth), 32'h0040);
    eth_in[47:32] = 16'h0040;
    tick(17);
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    chk("ack_pulse", 32'(a_ack), 32'h4);
    tick(11);
    chk("busy_ipg_last", 32'(a_busy), 1);
    tick(1);
    chk("busy_low", 32'(a_busy), 0);
    tick(3);

    // Fairness from a fresh reset.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      push_s(0, i % 4, (i == 0) ? 0 : 13);
      push_a(0, i % 4, 16'(i + 1), 6);
    end
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start(0);
      if (i == 4) req_a = 4'b0000;
      tick(5);
      done_a = 1'b1;
      tick(1);
      done_a = 1'b0;
    end
    tick(15);

    // Reset in the middle of a frame.
    push_s(0, 3, 0);
    req_a = 4'b1000;
    wait_start(0);
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(a_grant), 0);
    chk("mid_rst_start", 32'(a_start), 0);
    chk("mid_rst_eth", 32'(a_eth), 0);
    chk("mid_rst_busy", 32'(a_busy), 0);
    chk("mid_rst_cnt", 32'(a_cnt), 0);
    chk("mid_rst_to", 32'(a_to), 0);
    req_a = 4'b0011;
    tick(2);
    push_s(0, 0, 0);
    push_a(0, 0, 16'd1, 4);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_grant", 32'(a_grant), 32'h1);
    req_a = 4'b0000;
    tick(3);
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    tick(14);

    // Disabled scheduler ignores requests and stray done.
    en_a = 1'b0;
    req_a = 4'b0011;
    tick(3);
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    tick(16);
    chk("disabled_no_start", 32'(a_start), 0);
    chk("disabled_no_busy", 32'(a_busy), 0);
    push_s(0, 1, 0);
    push_a(0, 1, 16'd2, 3);
    en_a = 1'b1;
    wait_start(0);
    en_a = 1'b0;
    tick(2);
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    tick(30);
    chk("hold_after_disable", 32'(a_start), 0);
    req_a = 4'b0000;
    en_a = 1'b1;

    // Timeout with no done.
    push_s(1, 0, 0);
    t.d = 1; t.cnt = 16'd0; t.len = 16;
    tq.push_back(t);
    req_b = 4'b0001;
    wait_start(1);
    req_b = 4'b0000;
    tick(16);
    chk("b_to_pulse", 32'(b_to), 1);
    chk("b_to_no_ack", 32'(b_ack), 0);
    tick(2);

    // Done on the timeout cycle.
    push_s(1, 1, 0);
    push_a(1, 1, 16'd1, 16);
    req_b = 4'b0010;
    wait_start(1);
    req_b = 4'b0000;
    tick(15);
    done_b = 1'b1;
    tick(1);
    done_b = 1'b0;
    chk("b_race_no_to", 32'(b_to), 0);
    tick(2);

    // Saturation after preloading the counter.
    force dut_b.frame_cnt_q = 16'hFFFE;
    #1;
    release dut_b.frame_cnt_q;
    tick(1);
    chk("b_preload", 32'(b_cnt), 32'hFFFE);
    for (int k = 2; k < 4; k++) begin
      push_s(1, k, 0);
      push_a(1, k, 16'hFFFF, 1);
      req_b = 4'(1 << k);
      wait_start(1);
      req_b = 4'b0000;
      done_b = 1'b1;
      tick(1);
      done_b = 1'b0;
      tick(2);
    end
    chk("b_saturated", 32'(b_cnt), 32'hFFFF);

    tick(5);
    chk("start_q_empty", 32'(sq.size()), 0);
    chk("ack_q_empty", 32'(aq.size()), 0);
    chk("to_q_empty", 32'(tq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
